// File: rtl/pc_fetch_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : pc_fetch_unit                                               |
// | Description : Program-counter fetch stage in front of a synchronous       |
// |               instruction memory. One fetch per cycle, single-cycle      |
// |               redirect (absolute or PC-relative), stall with a hold       |
// |               buffer so that no fetched instruction is dropped or         |
// |               duplicated.                                                 |
// | Ports       : clk_i             clock, rising edge                        |
// |               reset_i           synchronous active-high reset             |
// |               stall_i           consumer not accepting this cycle         |
// |               redirect_valid_i  jump/branch taken this cycle              |
// |               redirect_mode_i   0 = absolute, 1 = relative to ins_pc_o    |
// |               redirect_target_i absolute address or signed offset         |
// |               imem_en_o         memory read enable                        |
// |               imem_addr_o       memory read address                       |
// |               imem_rdata_i      memory data, one cycle after imem_en_o    |
// |               ins_o             instruction presented to decode           |
// |               ins_pc_o          address of ins_o                          |
// |               ins_valid_o       ins_o/ins_pc_o are meaningful             |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module pc_fetch_unit #(
   parameter int unsigned     AW       = 8,
   parameter int unsigned     IW       = 24,
   parameter logic [AW-1:0]   RESET_PC = '0,
   parameter logic [IW-1:0]   NOP      = '0
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          stall_i,
   input  logic          redirect_valid_i,
   input  logic          redirect_mode_i,
   input  logic [AW-1:0] redirect_target_i,
   output logic          imem_en_o,
   output logic [AW-1:0] imem_addr_o,
   input  logic [IW-1:0] imem_rdata_i,
   output logic [IW-1:0] ins_o,
   output logic [AW-1:0] ins_pc_o,
   output logic          ins_valid_o
);

   logic [AW-1:0] pc_q;
   logic          req_valid_q;
   logic [AW-1:0] req_pc_q;
   logic          hold_active_q;
   logic [IW-1:0] hold_ins_q;
   logic [AW-1:0] hold_pc_q;
   logic          hold_valid_q;

   logic [IW-1:0] cur_ins;
   logic [AW-1:0] cur_pc;
   logic          cur_valid;
   logic [AW-1:0] redirect_addr;
   logic [AW-1:0] fetch_addr;
   logic          fetch_en;
   logic          capture_d;

   // Presented instruction: the hold buffer wins while it is active, otherwise
   // the memory data for the request issued last cycle.
   always_comb begin
      cur_ins   = req_valid_q ? imem_rdata_i : NOP;
      cur_pc    = req_valid_q ? req_pc_q     : '0;
      cur_valid = req_valid_q;
      if (hold_active_q) begin
         cur_ins   = hold_ins_q;
         cur_pc    = hold_pc_q;
         cur_valid = hold_valid_q;
      end
   end

   // Relative redirects are taken from the PC actually presented this cycle,
   // which may be the held one during a stall.
   always_comb begin
      redirect_addr = redirect_mode_i ? (cur_pc + redirect_target_i) : redirect_target_i;
      fetch_addr    = redirect_valid_i ? redirect_addr : pc_q;
      fetch_en      = !reset_i && (redirect_valid_i || !stall_i);
      capture_d     = stall_i && !redirect_valid_i && !hold_active_q;
   end

   assign imem_en_o   = fetch_en;
   assign imem_addr_o = fetch_addr;
   assign ins_o       = reset_i ? NOP  : cur_ins;
   assign ins_pc_o    = reset_i ? '0   : cur_pc;
   assign ins_valid_o = reset_i ? 1'b0 : cur_valid;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q          <= RESET_PC;
         req_valid_q   <= 1'b0;
         req_pc_q      <= '0;
         hold_active_q <= 1'b0;
         hold_ins_q    <= NOP;
         hold_pc_q     <= '0;
         hold_valid_q  <= 1'b0;
      end else begin
         if (fetch_en) begin
            pc_q        <= fetch_addr + AW'(1);
            req_pc_q    <= fetch_addr;
            req_valid_q <= 1'b1;
         end else begin
            req_valid_q <= 1'b0;
         end

         // Memory data is only visible for one cycle, so the first stalled
         // cycle snapshots the presented instruction into the hold buffer.
         if (capture_d) begin
            hold_ins_q    <= cur_ins;
            hold_pc_q     <= cur_pc;
            hold_valid_q  <= cur_valid;
            hold_active_q <= 1'b1;
         end else if (!stall_i || redirect_valid_i) begin
            hold_active_q <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire
